int_alu_pipe: RTL and testbench

- Two-stage elastic integer execute pipeline, directly downstream of the integer reservation station.
- Accepts one issued ALU uop per cycle, with operand values already read from the PRF. Stage 0 registers the operands; the ALU result is computed and registered into stage 1.
- Stage 1 presents the result on the CDB until the CDB arbiter grants it.
- Backpressure propagates to the reservation station through issue_ready.

---
 rtl/int_alu_types.sv | 54 +++++
 rtl/int_alu_pipe_alu_core.sv | 32 +++
 rtl/int_alu_pipe.sv | 124 ++++++++++++
 tb/tb_int_alu_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_alu_types.sv
// Shared types for the integer execute pipeline: opcodes, operand selects
// and the per-stage payload records.
package int_alu_types;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned PRF_IDX_W = 6;
  localparam int unsigned ARF_IDX_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_ZERO = 2'd1,
    OP1_PC   = 2'd2
  } op1_sel_t;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [ARF_IDX_W-1:0] rd_arch;
    op1_sel_t             op1_sel;
    op2_sel_t             op2_sel;
    alu_op_t              opcode;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
  } alu_s0_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [ARF_IDX_W-1:0] rd_arch;
    logic [XLEN-1:0]      value;
  } alu_s1_t;

endpackage

// File: rtl/int_alu_pipe_alu_core.sv
// Combinational integer ALU; undefined opcodes yield zero.
module alu_core
  import int_alu_types::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  opcode,
  output logic [31:0] result
);

  logic [4:0] shamt;

  assign shamt = op2[4:0];

  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLL:  result = op1 << shamt;
      ALU_SLT:  result = {31'd0, ($signed(op1) < $signed(op2))};
      ALU_SLTU: result = {31'd0, (op1 < op2)};
      ALU_XOR:  result = op1 ^ op2;
      ALU_SRL:  result = op1 >> shamt;
      ALU_SRA:  result = $signed(op1) >>> shamt;
      ALU_OR:   result = op1 | op2;
      ALU_AND:  result = op1 & op2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/int_alu_pipe.sv
// Two-stage elastic integer execute pipe: S0 holds the issued operands,
// S1 holds the computed result until the CDB arbiter grants it.
module int_alu_pipe
  import int_alu_types::*;
#(
  parameter int unsigned ROB_IDX = 5,
  parameter int unsigned PRF_IDX = 6,
  parameter int unsigned ARF_IDX = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [ROB_IDX-1:0] issue_rob_id,
  input  logic [PRF_IDX-1:0] issue_rd_phy,
  input  logic [ARF_IDX-1:0] issue_rd_arch,
  input  logic [1:0]         issue_op1_sel,
  input  logic               issue_op2_sel,
  input  logic [3:0]         issue_fu_opcode,
  input  logic [31:0]        issue_imm,
  input  logic [31:0]        issue_pc,
  input  logic [31:0]        issue_rs1_value,
  input  logic [31:0]        issue_rs2_value,
  output logic               cdb_valid,
  input  logic               cdb_ready,
  output logic [ROB_IDX-1:0] cdb_rob_id,
  output logic [PRF_IDX-1:0] cdb_rd_phy,
  output logic [ARF_IDX-1:0] cdb_rd_arch,
  output logic [31:0]        cdb_rd_value
);

  // Payload records are sized by the package; overrides must agree.
  if (ROB_IDX != ROB_IDX_W || PRF_IDX != PRF_IDX_W || ARF_IDX != ARF_IDX_W) begin : g_width_check
    $error("int_alu_pipe: index widths must match int_alu_types");
  end

  alu_s0_t     s0_q, s0_d;
  alu_s1_t     s1_q, s1_d;
  logic        s0_valid_q, s0_valid_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s0_ready, s1_ready;
  logic        issue_fire, s0_adv;
  logic [31:0] op1, op2, alu_res;

  assign s1_ready    = !s1_valid_q || cdb_ready;
  assign s0_ready    = !s0_valid_q || s1_ready;
  assign issue_ready = s0_ready && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign s0_adv      = s0_valid_q && s1_ready;

  always_comb begin
    op1 = '0;
    case (s0_q.op1_sel)
      OP1_RS1: op1 = s0_q.rs1_value;
      OP1_PC:  op1 = s0_q.pc;
      default: op1 = '0;
    endcase
    op2 = (s0_q.op2_sel == OP2_IMM) ? s0_q.imm : s0_q.rs2_value;
  end

  alu_core u_alu (
    .op1    (op1),
    .op2    (op2),
    .opcode (s0_q.opcode),
    .result (alu_res)
  );

  always_comb begin
    s0_d = s0_q;
    if (issue_fire) begin
      s0_d.rob_id    = issue_rob_id;
      s0_d.rd_phy    = issue_rd_phy;
      s0_d.rd_arch   = issue_rd_arch;
      s0_d.op1_sel   = op1_sel_t'(issue_op1_sel);
      s0_d.op2_sel   = op2_sel_t'(issue_op2_sel);
      s0_d.opcode    = alu_op_t'(issue_fu_opcode);
      s0_d.imm       = issue_imm;
      s0_d.pc        = issue_pc;
      s0_d.rs1_value = issue_rs1_value;
      s0_d.rs2_value = issue_rs2_value;
    end

    s1_d = s1_q;
    if (s0_adv) begin
      s1_d.rob_id  = s0_q.rob_id;
      s1_d.rd_phy  = s0_q.rd_phy;
      s1_d.rd_arch = s0_q.rd_arch;
      s1_d.value   = (s0_q.rd_arch == '0) ? '0 : alu_res;
    end

    // S0 stays occupied only while blocked, unless a new uop refills it.
    if (flush)            s0_valid_d = 1'b0;
    else if (issue_fire)  s0_valid_d = 1'b1;
    else if (s1_ready)    s0_valid_d = 1'b0;
    else                  s0_valid_d = s0_valid_q;

    if (flush)            s1_valid_d = 1'b0;
    else if (s1_ready)    s1_valid_d = s0_valid_q;
    else                  s1_valid_d = s1_valid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    s0_q <= s0_d;
    s1_q <= s1_d;
  end

  assign cdb_valid    = s1_valid_q;
  assign cdb_rob_id   = s1_valid_q ? s1_q.rob_id  : '0;
  assign cdb_rd_phy   = s1_valid_q ? s1_q.rd_phy  : '0;
  assign cdb_rd_arch  = s1_valid_q ? s1_q.rd_arch : '0;
  assign cdb_rd_value = s1_valid_q ? s1_q.value   : '0;

endmodule

// File: tb/tb_int_alu_pipe.sv
// Directed bench for int_alu_pipe: per-opcode vector table plus
// backpressure, streaming, flush and async-reset sequences.
module tb_int_alu_pipe;
  import int_alu_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_rob_id = '0;
  logic [5:0]  issue_rd_phy = '0;
  logic [4:0]  issue_rd_arch = '0;
  logic [1:0]  issue_op1_sel = '0;
  logic        issue_op2_sel = 1'b0;
  logic [3:0]  issue_fu_opcode = '0;
  logic [31:0] issue_imm = '0;
  logic [31:0] issue_pc = '0;
  logic [31:0] issue_rs1_value = '0;
  logic [31:0] issue_rs2_value = '0;
  logic        cdb_valid;
  logic        cdb_ready = 1'b1;
  logic [4:0]  cdb_rob_id;
  logic [5:0]  cdb_rd_phy;
  logic [4:0]  cdb_rd_arch;
  logic [31:0] cdb_rd_value;

  int total = 0;
  int bad = 0;

  int_alu_pipe #(.ROB_IDX(5), .PRF_IDX(6), .ARF_IDX(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_rob_id    (issue_rob_id),
    .issue_rd_phy    (issue_rd_phy),
    .issue_rd_arch   (issue_rd_arch),
    .issue_op1_sel   (issue_op1_sel),
    .issue_op2_sel   (issue_op2_sel),
    .issue_fu_opcode (issue_fu_opcode),
    .issue_imm       (issue_imm),
    .issue_pc        (issue_pc),
    .issue_rs1_value (issue_rs1_value),
    .issue_rs2_value (issue_rs2_value),
    .cdb_valid       (cdb_valid),
    .cdb_ready       (cdb_ready),
    .cdb_rob_id      (cdb_rob_id),
    .cdb_rd_phy      (cdb_rd_phy),
    .cdb_rd_arch     (cdb_rd_arch),
    .cdb_rd_value    (cdb_rd_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  s1;
    logic        s2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rob;
    logic [5:0]  phy;
    logic [4:0]  arch;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_uop(input logic [3:0] op, input logic [1:0] s1, input logic s2,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rob, input logic [5:0] phy, input logic [4:0] arch);
    issue_fu_opcode = op;
    issue_op1_sel   = s1;
    issue_op2_sel   = s2;
    issue_rs1_value = rs1;
    issue_rs2_value = rs2;
    issue_imm       = imm;
    issue_pc        = pc;
    issue_rob_id    = rob;
    issue_rd_phy    = phy;
    issue_rd_arch   = arch;
    issue_valid     = 1'b1;
  endtask

  task automatic issue_add(input logic [4:0] rob, input logic [31:0] a, input logic [31:0] b);
    set_uop(ALU_ADD, OP1_RS1, OP2_RS2, a, b, 32'd0, 32'd0, rob, {1'b0, rob}, 5'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{ALU_ADD,  OP1_RS1,  OP2_RS2, 32'd5,        32'd7,        32'd0,  32'd0,      5'd3,  6'd12, 5'd1,  32'd12};
    vecs[1]  = '{ALU_SRA,  OP1_RS1,  OP2_IMM, 32'h80000000, 32'd0,        32'd4,  32'd0,      5'd4,  6'd13, 5'd2,  32'hF8000000};
    vecs[2]  = '{ALU_SLTU, OP1_RS1,  OP2_RS2, 32'd1,        32'hFFFFFFFF, 32'd0,  32'd0,      5'd5,  6'd14, 5'd3,  32'd1};
    vecs[3]  = '{ALU_SLT,  OP1_RS1,  OP2_RS2, 32'd1,        32'hFFFFFFFF, 32'd0,  32'd0,      5'd6,  6'd15, 5'd4,  32'd0};
    vecs[4]  = '{ALU_ADD,  OP1_PC,   OP2_IMM, 32'h777,      32'd0,        32'h20, 32'h1000,   5'd7,  6'd16, 5'd5,  32'h1020};
    vecs[5]  = '{ALU_SUB,  OP1_RS1,  OP2_RS2, 32'd10,       32'd3,        32'd0,  32'd0,      5'd8,  6'd17, 5'd6,  32'd7};
    vecs[6]  = '{ALU_SLL,  OP1_RS1,  OP2_RS2, 32'd1,        32'h23,       32'd0,  32'd0,      5'd9,  6'd18, 5'd7,  32'd8};
    vecs[7]  = '{ALU_XOR,  OP1_RS1,  OP2_RS2, 32'hF0F0,     32'hFF00,     32'd0,  32'd0,      5'd10, 6'd19, 5'd8,  32'h0FF0};
    vecs[8]  = '{ALU_SRL,  OP1_RS1,  OP2_IMM, 32'h80000000, 32'd0,        32'h1F, 32'd0,      5'd11, 6'd20, 5'd9,  32'd1};
    vecs[9]  = '{ALU_OR,   OP1_RS1,  OP2_RS2, 32'hA0,       32'h05,       32'd0,  32'd0,      5'd12, 6'd21, 5'd10, 32'hA5};
    vecs[10] = '{ALU_AND,  OP1_RS1,  OP2_RS2, 32'hFF,       32'h3C,       32'd0,  32'd0,      5'd13, 6'd22, 5'd11, 32'h3C};
    vecs[11] = '{4'hF,     OP1_RS1,  OP2_RS2, 32'd5,        32'd7,        32'd0,  32'd0,      5'd14, 6'd23, 5'd12, 32'd0};
    vecs[12] = '{ALU_ADD,  OP1_ZERO, OP2_IMM, 32'h999,      32'd0,        32'h55, 32'd0,      5'd15, 6'd24, 5'd13, 32'h55};
    vecs[13] = '{ALU_ADD,  OP1_RS1,  OP2_RS2, 32'd3,        32'd4,        32'd0,  32'd0,      5'd16, 6'd25, 5'd0,  32'd0};
    vecs[14] = '{ALU_SRA,  OP1_RS1,  OP2_RS2, 32'h40000000, 32'd2,        32'd0,  32'd0,      5'd17, 6'd26, 5'd14, 32'h10000000};
    vecs[15] = '{ALU_SUB,  OP1_RS1,  OP2_RS2, 32'd0,        32'd1,        32'd0,  32'd0,      5'd18, 6'd27, 5'd15, 32'hFFFFFFFF};

    // Reset state
    @(negedge clk);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_cdb_value", cdb_rd_value, 0);
    chk("rst_cdb_rob", cdb_rob_id, 0);
    rst = 1'b1;

    // Single-issue vectors: value appears exactly two cycles after accept
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cdb_ready = 1'b1;
      set_uop(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].rs1, vecs[i].rs2,
              vecs[i].imm, vecs[i].pc, vecs[i].rob, vecs[i].phy, vecs[i].arch);
      #1 chk($sformatf("v%0d_issue_ready", i), issue_ready, 1);
      @(negedge clk);
      issue_valid = 1'b0;
      chk($sformatf("v%0d_n1_valid", i), cdb_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), cdb_valid, 1);
      chk($sformatf("v%0d_value", i), cdb_rd_value, vecs[i].exp);
      chk($sformatf("v%0d_rob", i), cdb_rob_id, vecs[i].rob);
      chk($sformatf("v%0d_phy", i), cdb_rd_phy, vecs[i].phy);
      chk($sformatf("v%0d_arch", i), cdb_rd_arch, vecs[i].arch);
      @(negedge clk);
      chk($sformatf("v%0d_after_valid", i), cdb_valid, 0);
      chk($sformatf("v%0d_gated_value", i), cdb_rd_value, 0);
    end

    // Backpressure: third uop blocked, head stable, in-order drain
    @(negedge clk);
    cdb_ready = 1'b0;
    issue_add(5'd1, 32'd100, 32'd1);
    #1 chk("bp_rdy_a", issue_ready, 1);
    @(negedge clk);
    issue_add(5'd2, 32'd100, 32'd2);
    #1 chk("bp_rdy_b", issue_ready, 1);
    @(negedge clk);
    issue_add(5'd3, 32'd100, 32'd3);
    #1 chk("bp_rdy_c", issue_ready, 0);
    chk("bp_head_valid", cdb_valid, 1);
    chk("bp_head_value", cdb_rd_value, 101);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("bp_stall%0d_rdy", k), issue_ready, 0);
      chk($sformatf("bp_stall%0d_valid", k), cdb_valid, 1);
      chk($sformatf("bp_stall%0d_value", k), cdb_rd_value, 101);
      chk($sformatf("bp_stall%0d_rob", k), cdb_rob_id, 1);
    end
    @(negedge clk);
    cdb_ready = 1'b1;
    #1 chk("bp_release_rdy", issue_ready, 1);
    chk("bp_ret_a_rob", cdb_rob_id, 1);
    chk("bp_ret_a_value", cdb_rd_value, 101);
    @(negedge clk);
    issue_valid = 1'b0;
    chk("bp_ret_b_valid", cdb_valid, 1);
    chk("bp_ret_b_rob", cdb_rob_id, 2);
    chk("bp_ret_b_value", cdb_rd_value, 102);
    @(negedge clk);
    chk("bp_ret_c_valid", cdb_valid, 1);
    chk("bp_ret_c_rob", cdb_rob_id, 3);
    chk("bp_ret_c_value", cdb_rd_value, 103);
    @(negedge clk);
    chk("bp_drained", cdb_valid, 0);

    // Streaming: ten back-to-back issues, ten consecutive results
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 12) begin
        chk($sformatf("st%0d_valid", c), cdb_valid, 1);
        chk($sformatf("st%0d_rob", c), cdb_rob_id, c - 2);
        chk($sformatf("st%0d_value", c), cdb_rd_value, 1000 + c - 2);
      end else begin
        chk($sformatf("st%0d_idle", c), cdb_valid, 0);
      end
      if (c < 10) begin
        issue_add(5'(c), 32'd1000, 32'(c));
        #1 chk($sformatf("st%0d_rdy", c), issue_ready, 1);
      end else begin
        issue_valid = 1'b0;
      end
    end

    // Flush with both stages full and the CDB stalled
    @(negedge clk);
    cdb_ready = 1'b0;
    issue_add(5'd4, 32'd1, 32'd1);
    @(negedge clk);
    issue_add(5'd5, 32'd2, 32'd2);
    @(negedge clk);
    issue_add(5'd6, 32'd3, 32'd3);
    flush = 1'b1;
    #1 chk("fl_rdy_during", issue_ready, 0);
    chk("fl_full_valid", cdb_valid, 1);
    @(negedge clk);
    flush = 1'b0;
    issue_valid = 1'b0;
    #1 chk("fl_after_valid", cdb_valid, 0);
    chk("fl_after_rdy", issue_ready, 1);
    @(negedge clk);
    chk("fl_s0_gone", cdb_valid, 0);
    cdb_ready = 1'b1;

    // Async reset while stalled
    @(negedge clk);
    cdb_ready = 1'b0;
    issue_add(5'd7, 32'd1, 32'd1);
    @(negedge clk);
    issue_add(5'd8, 32'd1, 32'd2);
    @(negedge clk);
    issue_valid = 1'b0;
    chk("ar_pre_valid", cdb_valid, 1);
    #2 rst = 1'b0;
    #1 chk("ar_valid_now", cdb_valid, 0);
    chk("ar_rdy_now", issue_ready, 1);
    chk("ar_rob_now", cdb_rob_id, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_post1_valid", cdb_valid, 0);
    @(negedge clk);
    chk("ar_post2_valid", cdb_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
